// File: rtl/sys_deser.sv
// Serial-to-parallel receiver: assembles a framed serial word, holds it for the
// host, and hands it out over a shared tristate bus under an active-low read strobe.
module sys_deser #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             Dbit_in,
  input  logic             Dbit_ena,
  input  logic             nRead,
  inout  wire  [WIDTH-1:0] databus,
  output logic             nData_rdy,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DRAIN
  } state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] holding;

  // Registered copies of the link and host strobes; every decision uses these.
  logic             ena_q;
  logic             bit_q;
  logic             nread_q;
  logic             nread_d;

  logic [WIDTH-1:0] shift_next;
  logic [CW-1:0]    count_inc;
  logic             read_done;
  logic             last_bit;

  always_comb begin
    shift_next = MSB_FIRST ? {shift_reg[WIDTH-2:0], bit_q}
                           : {bit_q, shift_reg[WIDTH-1:1]};
    count_inc  = count + CW'(1);
    read_done  = nread_q & ~nread_d;
    last_bit   = (count_inc == CW'(WIDTH));
  end

  // The raw pin gates the driver so the bus releases without waiting for a clock.
  assign databus = nRead ? {WIDTH{1'bz}} : holding;

  // NOTE: async-reset flops use non-blocking assignments only; blocking here would
  // make the result depend on statement order and mis-simulate against synthesis.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state     <= IDLE;
      count     <= '0;
      shift_reg <= '0;
      holding   <= '0;
      ena_q     <= 1'b0;
      bit_q     <= 1'b0;
      nread_q   <= 1'b1;
      nread_d   <= 1'b1;
      nData_rdy <= 1'b1;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      ena_q     <= Dbit_ena;
      bit_q     <= Dbit_in;
      nread_q   <= nRead;
      nread_d   <= nread_q;
      frame_err <= 1'b0;

      // NOTE: a later non-blocking assignment in the same cycle wins, which is how a
      // word completing alongside a read completion keeps nData_rdy low.
      if (read_done) begin
        nData_rdy <= 1'b1;
        overrun   <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (ena_q) begin
            shift_reg <= shift_next;
            count     <= CW'(1);
            state     <= SHIFT;
          end
        end

        SHIFT: begin
          if (ena_q) begin
            shift_reg <= shift_next;
            count     <= count_inc;
            if (last_bit) begin
              state <= DRAIN;
              if (nData_rdy || read_done) begin
                holding   <= shift_next;
                nData_rdy <= 1'b0;
              end else begin
                overrun <= 1'b1;
              end
            end
          end else begin
            frame_err <= 1'b1;
            shift_reg <= '0;
            count     <= '0;
            state     <= IDLE;
          end
        end

        DRAIN: begin
          if (!ena_q) begin
            count <= '0;
            state <= IDLE;
          end
        end

        default: begin
          count <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sys_deser.sv
// Bench for sys_deser: directed scenarios plus a randomized run against a
// word-level model of the receiver (pending word, holding value, overrun flag).
module tb_sys_deser;

  localparam int WIDTH = 8;
  localparam logic [WIDTH-1:0] RELEASED = 8'hFF;

  logic             clk = 1'b0;
  logic             nRst;
  logic             Dbit_in;
  logic             Dbit_ena;
  logic             nRead;
  wire  [WIDTH-1:0] databus;
  logic             nData_rdy;
  logic             frame_err;
  logic             overrun;

  int errors = 0;
  int checks = 0;
  int fe_pulses = 0;

  // A released bus floats up to all ones.
  for (genvar i = 0; i < WIDTH; i++) begin : g_pull
    pullup (databus[i]);
  end

  sys_deser #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut (
    .clk      (clk),
    .nRst     (nRst),
    .Dbit_in  (Dbit_in),
    .Dbit_ena (Dbit_ena),
    .nRead    (nRead),
    .databus  (databus),
    .nData_rdy(nData_rdy),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err === 1'b1) fe_pulses++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // Sends the top n bits of seq, first bit seq[15], then drops Dbit_ena.
  task automatic send_seq(input logic [15:0] seq, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      Dbit_ena = 1'b1;
      Dbit_in  = seq[15-i];
    end
    @(posedge clk); #1;
    Dbit_ena = 1'b0;
    Dbit_in  = 1'b0;
  endtask

  // One-cycle read strobe; returns the bus value while low and just after release.
  task automatic read_bus(output logic [WIDTH-1:0] during, output logic [WIDTH-1:0] after);
    @(posedge clk); #1;
    nRead = 1'b0;
    #2 during = databus;
    @(posedge clk); #1;
    nRead = 1'b1;
    #1 after = databus;
  endtask

  task automatic test_reset();
    logic [WIDTH-1:0] d, a;
    nRst = 1'b0; Dbit_in = 1'b0; Dbit_ena = 1'b0; nRead = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (nData_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b expected 1", nData_rdy); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    checks++; if (databus !== RELEASED) begin errors++; $display("FAIL reset_bus: got %h expected %h", databus, RELEASED); end
    @(posedge clk); #1 nRst = 1'b1;

    send_seq({8'h5A, 8'h00}, 8);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (nData_rdy !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b expected 0", nData_rdy); end

    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      Dbit_ena = 1'b1;
      Dbit_in  = 1'b1;
    end
    @(negedge clk);
    nRst = 1'b0;
    #1;
    checks++; if (nData_rdy !== 1'b1) begin errors++; $display("FAIL reset_async_rdy: got %b expected 1", nData_rdy); end
    nRead = 1'b0;
    #1;
    checks++; if (databus !== 8'h00) begin errors++; $display("FAIL reset_holding: got %h expected 00", databus); end
    nRead = 1'b1;
    Dbit_ena = 1'b0;
    Dbit_in = 1'b0;
    #1;
    checks++; if (databus !== RELEASED) begin errors++; $display("FAIL reset_bus_release: got %h expected %h", databus, RELEASED); end
    @(posedge clk); #1 nRst = 1'b1;

    send_seq({8'hA5, 8'h00}, 8);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (nData_rdy !== 1'b0) begin errors++; $display("FAIL reset_next_rdy: got %b expected 0", nData_rdy); end
    read_bus(d, a);
    checks++; if (d !== 8'hA5) begin errors++; $display("FAIL reset_next_word: got %h expected A5", d); end
    repeat (2) @(posedge clk); #1;
    checks++; if (nData_rdy !== 1'b1) begin errors++; $display("FAIL reset_next_clear: got %b expected 1", nData_rdy); end
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] d, a;
    send_seq({8'b1001_1001, 8'h00}, 8);
    @(negedge clk);
    checks++; if (nData_rdy !== 1'b1) begin errors++; $display("FAIL basic_early_rdy: got %b expected 1", nData_rdy); end
    @(posedge clk); @(negedge clk);
    checks++; if (nData_rdy !== 1'b0) begin errors++; $display("FAIL basic_rdy: got %b expected 0", nData_rdy); end
    read_bus(d, a);
    checks++; if (d !== 8'h99) begin errors++; $display("FAIL basic_word: got %h expected 99", d); end
    checks++; if (a !== RELEASED) begin errors++; $display("FAIL basic_release: got %h expected %h", a, RELEASED); end
    @(posedge clk); @(negedge clk);
    checks++; if (nData_rdy !== 1'b0) begin errors++; $display("FAIL basic_clear_early: got %b expected 0", nData_rdy); end
    @(posedge clk); @(negedge clk);
    checks++; if (nData_rdy !== 1'b1) begin errors++; $display("FAIL basic_clear: got %b expected 1", nData_rdy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL basic_overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] words [3] = '{8'h99, 8'h9A, 8'h9B};
    fork
      begin
        for (int j = 0; j < 3; j++) send_seq({words[j], 8'h00}, 8);
      end
      begin
        logic [WIDTH-1:0] d, a;
        for (int j = 0; j < 3; j++) begin
          int t = 0;
          while (nData_rdy !== 1'b0 && t < 40) begin @(negedge clk); t++; end
          checks++; if (t >= 40) begin errors++; $display("FAIL b2b_wait%0d: got no word expected word within 40 cycles", j); end
          read_bus(d, a);
          checks++; if (d !== words[j]) begin errors++; $display("FAIL b2b_word%0d: got %h expected %h", j, d, words[j]); end
          repeat (2) @(posedge clk); #1;
          checks++; if (nData_rdy !== 1'b1) begin errors++; $display("FAIL b2b_clear%0d: got %b expected 1", j, nData_rdy); end
          checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun%0d: got %b expected 0", j, overrun); end
        end
      end
    join
  endtask

  task automatic test_overrun();
    logic [WIDTH-1:0] d, a;
    send_seq({8'h11, 8'h00}, 8);
    repeat (2) @(posedge clk); #1;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_first: got %b expected 0", overrun); end
    send_seq({8'h22, 8'h00}, 8);
    repeat (2) @(posedge clk); #1;
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b expected 1", overrun); end
    checks++; if (nData_rdy !== 1'b0) begin errors++; $display("FAIL ovr_rdy: got %b expected 0", nData_rdy); end
    read_bus(d, a);
    checks++; if (d !== 8'h11) begin errors++; $display("FAIL ovr_word: got %h expected 11", d); end
    repeat (2) @(posedge clk); #1;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b expected 0", overrun); end
    checks++; if (nData_rdy !== 1'b1) begin errors++; $display("FAIL ovr_rdy_clear: got %b expected 1", nData_rdy); end
  endtask

  task automatic test_frame_err();
    logic [WIDTH-1:0] d, a;
    int base = fe_pulses;
    send_seq({8'hB8, 8'h00}, 5);
    repeat (4) @(posedge clk); #1;
    checks++; if (fe_pulses - base !== 1) begin errors++; $display("FAIL ferr_pulse: got %0d cycles expected 1", fe_pulses - base); end
    checks++; if (nData_rdy !== 1'b1) begin errors++; $display("FAIL ferr_rdy: got %b expected 1", nData_rdy); end
    send_seq({8'h3C, 8'h00}, 8);
    repeat (2) @(posedge clk); #1;
    checks++; if (nData_rdy !== 1'b0) begin errors++; $display("FAIL ferr_next_rdy: got %b expected 0", nData_rdy); end
    read_bus(d, a);
    checks++; if (d !== 8'h3C) begin errors++; $display("FAIL ferr_next_word: got %h expected 3C", d); end
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_long_frame();
    logic [WIDTH-1:0] d, a;
    int base = fe_pulses;
    send_seq({8'hF0, 8'b1100_0000}, 10);
    repeat (4) @(posedge clk); #1;
    checks++; if (fe_pulses - base !== 0) begin errors++; $display("FAIL long_ferr: got %0d cycles expected 0", fe_pulses - base); end
    checks++; if (nData_rdy !== 1'b0) begin errors++; $display("FAIL long_rdy: got %b expected 0", nData_rdy); end
    read_bus(d, a);
    checks++; if (d !== 8'hF0) begin errors++; $display("FAIL long_word: got %h expected F0", d); end
    repeat (2) @(posedge clk); #1;
    checks++; if (nData_rdy !== 1'b1) begin errors++; $display("FAIL long_clear: got %b expected 1", nData_rdy); end
  endtask

  task automatic test_collision();
    logic [WIDTH-1:0] d, a, early;
    send_seq({8'h5A, 8'h00}, 8);
    repeat (2) @(posedge clk); #1;
    // Read strobe rises with the last bit, so its registered edge meets the completion.
    fork
      send_seq({8'hC3, 8'h00}, 8);
      begin
        repeat (7) @(posedge clk);
        #1 nRead = 1'b0;
        #2 early = databus;
        @(posedge clk);
        #1 nRead = 1'b1;
      end
    join
    checks++; if (early !== 8'h5A) begin errors++; $display("FAIL coll_old_word: got %h expected 5A", early); end
    @(negedge clk);
    checks++; if (nData_rdy !== 1'b0) begin errors++; $display("FAIL coll_rdy_pre: got %b expected 0", nData_rdy); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      checks++; if (nData_rdy !== 1'b0) begin errors++; $display("FAIL coll_rdy%0d: got %b expected 0", i, nData_rdy); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL coll_overrun%0d: got %b expected 0", i, overrun); end
    end
    read_bus(d, a);
    checks++; if (d !== 8'hC3) begin errors++; $display("FAIL coll_new_word: got %h expected C3", d); end
    repeat (2) @(posedge clk); #1;
    checks++; if (nData_rdy !== 1'b1) begin errors++; $display("FAIL coll_clear: got %b expected 1", nData_rdy); end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] held = 8'hC3;
    logic             pending = 1'b0;
    logic             lost = 1'b0;
    for (int it = 0; it < 30; it++) begin
      logic [WIDTH-1:0] data, extra, d, a;
      int n, base;
      data  = WIDTH'($urandom);
      extra = WIDTH'($urandom);
      n     = $urandom_range(5, 11);
      base  = fe_pulses;
      send_seq({data, extra}, n);
      repeat (3) @(posedge clk); #1;
      if (n >= WIDTH) begin
        if (!pending) begin held = data; pending = 1'b1; end
        else lost = 1'b1;
      end
      checks++; if (fe_pulses - base !== ((n < WIDTH) ? 1 : 0)) begin errors++; $display("FAIL rnd%0d_ferr: got %0d expected %0d (n=%0d)", it, fe_pulses - base, (n < WIDTH) ? 1 : 0, n); end
      checks++; if (nData_rdy !== ~pending) begin errors++; $display("FAIL rnd%0d_rdy: got %b expected %b", it, nData_rdy, ~pending); end
      checks++; if (overrun !== lost) begin errors++; $display("FAIL rnd%0d_overrun: got %b expected %b", it, overrun, lost); end
      if ($urandom_range(0, 2) != 0) begin
        read_bus(d, a);
        checks++; if (d !== held) begin errors++; $display("FAIL rnd%0d_word: got %h expected %h", it, d, held); end
        checks++; if (a !== RELEASED) begin errors++; $display("FAIL rnd%0d_release: got %h expected %h", it, a, RELEASED); end
        repeat (2) @(posedge clk); #1;
        pending = 1'b0;
        lost = 1'b0;
        checks++; if (nData_rdy !== 1'b1 || overrun !== 1'b0) begin errors++; $display("FAIL rnd%0d_clear: got rdy=%b ovr=%b expected rdy=1 ovr=0", it, nData_rdy, overrun); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_overrun();
    test_frame_err();
    test_long_frame();
    test_collision();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sys_deser.md
Name: sys_deser

Overview:
- Serial-to-parallel receiver; the far end of the serial link driven by the sys AD-grab block.
- Collects a framed serial word from Dbit_in / Dbit_ena, holds it, and raises an active-low ready strobe to the host.
- The host reads the word over the shared bidirectional databus with an active-low read strobe.
- Single clock domain; sits between the serial link and the 8-bit host data bus.

Parameters:
- WIDTH, 8, data word width and number of serial bits per frame.
- MSB_FIRST, 1, 1 = first received bit lands in bit WIDTH-1; 0 = first bit lands in bit 0.

Ports:
- clk  input  1  system clock; all sampling on the rising edge.
- nRst  input  1  asynchronous, active-low reset.
- Dbit_in  input  1  serial data bit; valid on clk rising edges while Dbit_ena=1.
- Dbit_ena  input  1  frame qualifier; high for the whole frame, low between frames.
- nRead  input  1  host read strobe, active low.
- databus  inout  WIDTH  shared host bus; driven only while nRead=0, otherwise high-Z.
- nData_rdy  output  1  low = unread word in the holding register.
- frame_err  output  1  one-cycle pulse when a frame is malformed.
- overrun  output  1  sticky; set when a complete word is lost because the previous one was unread.

Behaviour:
- Reset (nRst=0, asynchronous):
  - state=IDLE, bit counter=0, shift register=0, holding register=0.
  - nData_rdy=1, frame_err=0, overrun=0, databus=Z.
  - A reset asserted mid-frame or mid-read aborts the operation immediately.
- Synchronisers: Dbit_ena and nRead are registered once. Dbit_in is registered alongside Dbit_ena so the two stay aligned. All FSM decisions use the registered copies.
- FSM states: IDLE, SHIFT, DRAIN.
- IDLE:
  - On registered Dbit_ena=1: shift in the first bit, counter=1, go to SHIFT.
- SHIFT:
  - Each cycle with Dbit_ena=1: shift in one bit (MSB_FIRST ordering) and increment the counter.
  - When the counter reaches WIDTH, on that same cycle:
    - If nData_rdy=1: holding register <= assembled word; nData_rdy goes to 0 on the following cycle.
    - If nData_rdy=0 (previous word unread): discard the new word, keep the holding register, set overrun.
    - Then go to DRAIN.
  - Dbit_ena=0 while counter<WIDTH: frame_err pulses for 1 cycle, the partial word is discarded, counter=0, go to IDLE.
- DRAIN:
  - Ignore Dbit_in until Dbit_ena=0, then go to IDLE.
  - Extra bits beyond WIDTH are not an error.
- Latency: nData_rdy falls 2 clk cycles after the rising edge that presents the last serial bit (1 cycle for the synchroniser, 1 for the holding-register update).
- Read handshake:
  - While nRead=0 (raw, combinational), databus = holding register. No tristate-enable latency, so the bus is valid within one propagation delay.
  - Bus-to-Z timing: the raw pin controls tristate; the registered copy controls handshake state. databus returns to Z as soon as nRead=1.
  - Detection: the registered nRead rising edge (0->1) marks read completion.
  - On that edge: nData_rdy=1 and overrun is cleared.
  - A read while nData_rdy=1 drives stale holding data and has no other effect.
- Simultaneous events:
  - A read-completion edge and a word completion in the same cycle count as "read first". The new word is loaded, nData_rdy stays 0, and overrun is not set.
  - Dbit_ena may rise in the cycle immediately after leaving DRAIN. IDLE accepts it with no gap cycle required.
- Arithmetic:
  - Counter width is $clog2(WIDTH)+1.
  - The counter never wraps: it saturates at WIDTH in DRAIN.

Test Plan:
- Reset: hold nRst=0 mid-frame after 3 bits, release -> nData_rdy=1, overrun=0, databus=Z; the next full frame 8'hA5 is received correctly.
- Basic receive, MSB_FIRST=1: send bits 1,0,0,1,1,0,0,1 under Dbit_ena -> nData_rdy=0 two cycles after the last bit. Pulse nRead low -> databus=8'h99 while low, Z after. nData_rdy=1 two cycles after nRead rises.
- Back-to-back: frames 8'h99, 8'h9A, 8'h9B sent with one idle cycle between them, each read before the next completes -> reads return 99, 9A, 9B; overrun stays 0.
- Overrun: send 8'h11 and do not read; send 8'h22 -> overrun=1 and a read returns 8'h11. After nRead rises, overrun=0 and nData_rdy=1.
- Frame error: Dbit_ena drops after 5 bits -> frame_err high for exactly 1 cycle and nData_rdy unchanged. A following frame 8'h3C is received correctly.
- Long frame plus collision: 10 bits under one Dbit_ena with the first 8 forming 8'hF0 -> word 8'hF0, no error. Separately, nRead rising in the same cycle as a word completion -> new word loaded, nData_rdy stays 0, overrun=0.
